// File: rtl/nibble_deserializer.sv
// Serial-to-nibble receiver: start/4 data/even parity/stop frames, strobed by sin_en,
// delivered through a 2-entry FIFO with a ready/valid consumer interface.
module nibble_deserializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_en,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       par_err,
    output logic       frm_err,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    logic [1:0] bit_cnt;
    logic [3:0] shreg;
    logic       par_bit;

    // entry0 is always the head, so out_data comes straight from a register
    logic [3:0] entry0;
    logic [3:0] entry1;
    logic [1:0] count;

    logic pop;
    logic stop_edge;
    logic frame_ok;
    logic push;
    logic drop_full;

    assign out_valid = (count != 2'd0);
    assign out_data  = entry0;

    always_comb begin
        pop       = out_valid && out_ready;
        stop_edge = sin_en && (state == STOP);
        frame_ok  = !sin && (par_bit == ^shreg);
        // A same-edge pop frees a slot, so a full buffer can still accept the frame
        push      = stop_edge && frame_ok && ((count != 2'd2) || pop);
        drop_full = stop_edge && frame_ok && !push;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 2'd0;
            shreg   <= 4'd0;
            par_bit <= 1'b0;
            busy    <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle; only the STOP strobe raises them.
            par_err <= 1'b0;
            frm_err <= 1'b0;
            ovf     <= 1'b0;
            if (sin_en) begin
                case (state)
                    IDLE: begin
                        if (sin) begin
                            state   <= DATA;
                            bit_cnt <= 2'd0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {shreg[2:0], sin};
                        bit_cnt <= bit_cnt + 2'd1;
                        if (bit_cnt == 2'd3) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= sin;
                        state   <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        frm_err <= sin;
                        par_err <= !sin && (par_bit != ^shreg);
                        ovf     <= drop_full;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: the two FIFO entries are reset because out_data must read 0 while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= 4'd0;
            entry1 <= 4'd0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= shreg;
                    else               entry1 <= shreg;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= shreg;
                    end else begin
                        entry0 <= shreg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed bench for nibble_deserializer: hand-built frames with hand-computed results.
module tb_nibble_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_en;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       par_err;
    logic       frm_err;
    logic       ovf;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    nibble_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frm_err   (frm_err),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one input cycle, then settle just after the rising edge.
    task automatic drive(input logic b, input logic en);
        sin    = b;
        sin_en = en;
        @(posedge clk);
        #1;
    endtask

    // Send the first n bits of a frame given as {start, d3, d2, d1, d0, parity, stop}.
    task automatic send_bits(input logic [6:0] bits, input int n, input bit gap);
        for (int i = 6; i > 6 - n; i--) begin
            drive(bits[i], 1'b1);
            if (gap) drive(~bits[i], 1'b0);
        end
    endtask

    task automatic chk_flags(input string tag, input logic pe, input logic fe, input logic of);
        check({tag, "_par_err"}, par_err, pe);
        check({tag, "_frm_err"}, frm_err, fe);
        check({tag, "_ovf"},     ovf,     of);
    endtask

    initial begin
        rst       = 1'b1;
        sin       = 1'b0;
        sin_en    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  4'h0);
        check("rst_busy",  busy,      1'b0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Good frame 1010, consumer always ready
        out_ready = 1'b1;
        send_bits(7'b1_1010_0_0, 1, 1'b0);
        check("s1_busy", busy, 1'b1);
        send_bits(7'b0_1010_0_0 << 0, 0, 1'b0);
        drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1); drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        check("s1_valid", out_valid, 1'b1);
        check("s1_data",  out_data,  4'b1010);
        check("s1_busy_end", busy, 1'b0);
        chk_flags("s1", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1);
        check("s1_popped", out_valid, 1'b0);

        // Parity error: data 0111 with parity 0
        send_bits(7'b1_0111_0_0, 7, 1'b0);
        check("s2_par_err", par_err, 1'b1);
        check("s2_frm_err", frm_err, 1'b0);
        check("s2_valid",   out_valid, 1'b0);
        drive(1'b0, 1'b1);
        check("s2_pulse_end", par_err, 1'b0);

        // Bad stop bit with correct parity: data 0001, parity 1, stop 1
        send_bits(7'b1_0001_1_1, 7, 1'b0);
        check("s3_frm_err", frm_err, 1'b1);
        check("s3_par_err", par_err, 1'b0);
        check("s3_valid",   out_valid, 1'b0);
        drive(1'b0, 1'b1);
        check("s3_pulse_end", frm_err, 1'b0);
        check("s3_no_push",   out_valid, 1'b0);

        // Overflow: three back-to-back good frames with no consumer
        out_ready = 1'b0;
        send_bits(7'b1_0001_1_0, 7, 1'b0);
        send_bits(7'b1_0010_1_0, 7, 1'b0);
        check("s4_valid", out_valid, 1'b1);
        check("s4_head",  out_data,  4'b0001);
        chk_flags("s4_two", 1'b0, 1'b0, 1'b0);
        send_bits(7'b1_0100_1_0, 7, 1'b0);
        chk_flags("s4_third", 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1);
        check("s4_ovf_end",   ovf,      1'b0);
        check("s4_hold_data", out_data, 4'b0001);
        check("s4_hold_vld",  out_valid, 1'b1);
        out_ready = 1'b1;
        drive(1'b0, 1'b1);
        check("s4_pop1_data", out_data,  4'b0010);
        check("s4_pop1_vld",  out_valid, 1'b1);
        drive(1'b0, 1'b1);
        check("s4_empty", out_valid, 1'b0);

        // Full buffer with a pop on the STOP edge of a third frame
        out_ready = 1'b0;
        send_bits(7'b1_0001_1_0, 7, 1'b0);
        send_bits(7'b1_0010_1_0, 7, 1'b0);
        send_bits(7'b1_0011_0_0, 6, 1'b0);
        out_ready = 1'b1;
        drive(1'b0, 1'b1);
        chk_flags("s5", 1'b0, 1'b0, 1'b0);
        check("s5_head1", out_data,  4'b0010);
        check("s5_vld1",  out_valid, 1'b1);
        drive(1'b0, 1'b1);
        check("s5_head2", out_data,  4'b0011);
        check("s5_vld2",  out_valid, 1'b1);
        drive(1'b0, 1'b1);
        check("s5_empty", out_valid, 1'b0);

        // Gapped strobes for 1001, then reset mid-frame, then 1100
        send_bits(7'b1_1001_0_0, 6, 1'b1);
        drive(1'b0, 1'b1);
        check("s6_valid", out_valid, 1'b1);
        check("s6_data",  out_data,  4'b1001);
        chk_flags("s6", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0);
        check("s6_pop_no_strobe", out_valid, 1'b0);
        send_bits(7'b1_1100_0_0, 4, 1'b0);
        check("s6_busy_mid", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("s6_rst_busy",  busy,      1'b0);
        check("s6_rst_valid", out_valid, 1'b0);
        drive(1'b0, 1'b1);
        rst = 1'b0;
        drive(1'b0, 1'b1);
        check("s6_idle_after", busy, 1'b0);
        send_bits(7'b1_1100_0_0, 7, 1'b0);
        check("s6_new_valid", out_valid, 1'b1);
        check("s6_new_data",  out_data,  4'b1100);
        chk_flags("s6_new", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
